// File: rtl/pipe_hazard_ctrl_if.sv
// Redirect handshake between the hazard controller and the fetch/commit logic:
// exception commit in, PC redirect out.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              exc_valid_i;
    logic              exc_is_eret_i;
    logic [ADDR_W-1:0] cp0_epc_i;
    logic              fetch_ready_i;
    logic              redirect_valid_o;
    logic [ADDR_W-1:0] redirect_pc_o;

    modport master (
        output exc_valid_i, exc_is_eret_i, cp0_epc_i, fetch_ready_i,
        input  redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  exc_valid_i, exc_is_eret_i, cp0_epc_i, fetch_ready_i,
        output redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation, exception and
// ERET redirect with a held-redirect state, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int                NUM_STAGES = 5,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'hBFC00380),
    parameter int                CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  global_stall_i,
    input  logic [NUM_STAGES-1:0] stage_stall_req_i,
    input  logic [4:0]            id_rs_addr_i,
    input  logic [4:0]            id_rt_addr_i,
    input  logic                  id_rs_ren_i,
    input  logic                  id_rt_ren_i,
    input  logic                  id_needs_early_i,
    input  logic [4:0]            ex_rs_addr_i,
    input  logic [4:0]            ex_rt_addr_i,
    input  logic                  ex_rs_ren_i,
    input  logic                  ex_rt_ren_i,
    input  logic                  ex_wreg_i,
    input  logic [4:0]            ex_wd_i,
    input  logic                  mem_is_load_i,
    input  logic [4:0]            mem_wd_i,
    pipe_hazard_ctrl_if.slave     redir_if,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_e;

    localparam logic [NUM_STAGES-1:0] EXC_FLUSH  = {1'b0, {(NUM_STAGES-1){1'b1}}};
    localparam logic [NUM_STAGES-1:0] PEND_FLUSH = NUM_STAGES'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q;

    logic                  early_hazard;
    logic                  load_use;
    logic [NUM_STAGES-1:0] req;
    logic [NUM_STAGES-1:0] haz_stall;
    logic [NUM_STAGES-1:0] haz_flush;
    logic                  older_req;
    logic [ADDR_W-1:0]     exc_target;

    always_comb begin
        early_hazard = id_needs_early_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                       ((id_rs_ren_i & (id_rs_addr_i == ex_wd_i)) |
                        (id_rt_ren_i & (id_rt_addr_i == ex_wd_i)));
        load_use     = mem_is_load_i & (mem_wd_i != 5'd0) &
                       ((ex_rs_ren_i & (ex_rs_addr_i == mem_wd_i)) |
                        (ex_rt_ren_i & (ex_rt_addr_i == mem_wd_i)));

        req    = stage_stall_req_i;
        req[1] = req[1] | early_hazard;
        req[2] = req[2] | load_use;

        // Walk from the oldest stage down so each stall covers all younger stages;
        // the bubble goes only behind the oldest requesting stage.
        older_req = 1'b0;
        haz_stall = '0;
        haz_flush = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (i < NUM_STAGES - 1) begin
                haz_flush[i] = req[i] & ~older_req & ~global_stall_i;
            end
            older_req    = older_req | req[i];
            haz_stall[i] = global_stall_i | older_req;
        end
    end

    assign exc_target = redir_if.exc_is_eret_i ? redir_if.cp0_epc_i : EXC_VECTOR;

    always_comb begin
        state_d                   = state_q;
        pc_d                      = pc_q;
        stall_o                   = haz_stall;
        flush_o                   = haz_flush;
        redir_if.redirect_valid_o = 1'b0;
        redir_if.redirect_pc_o    = '0;

        case (state_q)
            IDLE: begin
                if (redir_if.exc_valid_i) begin
                    redir_if.redirect_valid_o = 1'b1;
                    redir_if.redirect_pc_o    = exc_target;
                    pc_d                      = exc_target;
                    stall_o                   = '0;
                    flush_o                   = EXC_FLUSH;
                    if (!redir_if.fetch_ready_i) begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                // The held target is presented until fetch accepts it; a new
                // exception replaces it and restarts the wait.
                redir_if.redirect_valid_o = 1'b1;
                redir_if.redirect_pc_o    = pc_q;
                stall_o                   = '0;
                flush_o                   = PEND_FLUSH;
                if (redir_if.exc_valid_i) begin
                    pc_d    = exc_target;
                    flush_o = EXC_FLUSH;
                end else if (redir_if.fetch_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!resetn_i) begin
            stall_o                   = '0;
            flush_o                   = '0;
            redir_if.redirect_valid_o = 1'b0;
            redir_if.redirect_pc_o    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if ((|stall_o) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle hazard vectors plus
// hand-written exception, reset and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] EPC     = 32'h80001234;

    logic        clk = 1'b0;
    logic        resetn;
    logic        global_stall;
    logic [4:0]  stage_req;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wd, mem_wd;
    logic        id_rs_ren, id_rt_ren, id_early, ex_rs_ren, ex_rt_ren, ex_wreg, mem_load;
    logic [4:0]  stall, flush, stall4, flush4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;
    int expCnt = 0;

    pipe_hazard_ctrl_if #(.ADDR_W(32)) rif ();
    pipe_hazard_ctrl_if #(.ADDR_W(32)) rif4 ();

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .resetn_i(resetn), .global_stall_i(global_stall),
        .stage_stall_req_i(stage_req),
        .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt), .id_rs_ren_i(id_rs_ren),
        .id_rt_ren_i(id_rt_ren), .id_needs_early_i(id_early),
        .ex_rs_addr_i(ex_rs), .ex_rt_addr_i(ex_rt), .ex_rs_ren_i(ex_rs_ren),
        .ex_rt_ren_i(ex_rt_ren), .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd),
        .mem_is_load_i(mem_load), .mem_wd_i(mem_wd),
        .redir_if(rif), .stall_o(stall), .flush_o(flush), .stall_cycles_o(cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .resetn_i(resetn), .global_stall_i(global_stall),
        .stage_stall_req_i(stage_req),
        .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt), .id_rs_ren_i(id_rs_ren),
        .id_rt_ren_i(id_rt_ren), .id_needs_early_i(id_early),
        .ex_rs_addr_i(ex_rs), .ex_rt_addr_i(ex_rt), .ex_rs_ren_i(ex_rs_ren),
        .ex_rt_ren_i(ex_rt_ren), .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd),
        .mem_is_load_i(mem_load), .mem_wd_i(mem_wd),
        .redir_if(rif4), .stall_o(stall4), .flush_o(flush4), .stall_cycles_o(cnt4)
    );

    typedef struct {
        logic       gstall;
        logic [4:0] sreq;
        logic       early;
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       idRsRen;
        logic       idRtRen;
        logic       exWreg;
        logic [4:0] exWd;
        logic [4:0] exRs;
        logic [4:0] exRt;
        logic       exRsRen;
        logic       exRtRen;
        logic       memLoad;
        logic [4:0] memWd;
        logic [4:0] expStall;
        logic [4:0] expFlush;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        global_stall = v.gstall;
        stage_req    = v.sreq;
        id_early     = v.early;
        id_rs        = v.idRs;
        id_rt        = v.idRt;
        id_rs_ren    = v.idRsRen;
        id_rt_ren    = v.idRtRen;
        ex_wreg      = v.exWreg;
        ex_wd        = v.exWd;
        ex_rs        = v.exRs;
        ex_rt        = v.exRt;
        ex_rs_ren    = v.exRsRen;
        ex_rt_ren    = v.exRtRen;
        mem_load     = v.memLoad;
        mem_wd       = v.memWd;
    endtask

    task automatic setExc(input logic exc, input logic eret, input logic [31:0] epc, input logic fr);
        rif.exc_valid_i   = exc;
        rif.exc_is_eret_i = eret;
        rif.cp0_epc_i     = epc;
        rif.fetch_ready_i = fr;
    endtask

    // Samples one cycle at the falling edge, then advances to just past the next rising edge.
    task automatic checkCycle(input string tag, input logic expRv, input logic chkPc,
                              input logic [31:0] expPc, input logic [4:0] expStall,
                              input logic [4:0] expFlush);
        @(negedge clk);
        checkOutput({tag, ".redirect_valid"}, 32'(rif.redirect_valid_o), 32'(expRv));
        if (chkPc) checkOutput({tag, ".redirect_pc"}, rif.redirect_pc_o, expPc);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(expStall));
        checkOutput({tag, ".flush"}, 32'(flush), 32'(expFlush));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           g     sreq      e     idRs   idRt   rsR   rtR   wreg  exWd   exRs   exRt   rsR   rtR   ld    memWd  stall     flush
        vecs[0]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00000, 5'b00000};
        vecs[1]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  5'b00111, 5'b00100};
        vecs[2]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd7,  1'b0, 1'b1, 1'b1, 5'd7,  5'b00111, 5'b00100};
        vecs[3]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  5'b00000, 5'b00000};
        vecs[4]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  5'b00000, 5'b00000};
        vecs[5]  = '{1'b0, 5'b00000, 1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00011, 5'b00010};
        vecs[6]  = '{1'b0, 5'b00000, 1'b1, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00000, 5'b00000};
        vecs[7]  = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00000, 5'b00000};
        vecs[8]  = '{1'b0, 5'b00000, 1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00000, 5'b00000};
        vecs[9]  = '{1'b0, 5'b00000, 1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00011, 5'b00010};
        vecs[10] = '{1'b1, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  5'b11111, 5'b00000};
        vecs[11] = '{1'b1, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b11111, 5'b00000};
        vecs[12] = '{1'b0, 5'b01000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b01111, 5'b01000};
        vecs[13] = '{1'b0, 5'b10000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b11111, 5'b00000};
        vecs[14] = '{1'b0, 5'b01000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  5'b01111, 5'b01000};
        vecs[15] = '{1'b0, 5'b00001, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b00001, 5'b00001};
        vecs[16] = '{1'b0, 5'b00000, 1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  5'b00111, 5'b00100};
        vecs[17] = '{1'b0, 5'b01010, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'b01111, 5'b01000};
        vecs[18] = '{1'b0, 5'b00000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd6,  5'b00000, 5'b00000};

        applyStimulus(vecs[0]);
        setExc(1'b1, 1'b0, 32'h0, 1'b0);
        rif4.exc_valid_i   = 1'b0;
        rif4.exc_is_eret_i = 1'b0;
        rif4.cp0_epc_i     = 32'h0;
        rif4.fetch_ready_i = 1'b1;
        global_stall = 1'b1;
        resetn = 1'b0;

        // Reset holds every output low even with a stall and exception driven.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.redirect_valid", 32'(rif.redirect_valid_o), 32'h0);
        checkOutput("rst.redirect_pc", rif.redirect_pc_o, 32'h0);
        checkOutput("rst.stall", 32'(stall), 32'h0);
        checkOutput("rst.flush", 32'(flush), 32'h0);
        checkOutput("rst.cnt", cnt, 32'h0);
        applyStimulus(vecs[0]);
        setExc(1'b0, 1'b0, 32'h0, 1'b1);
        resetn = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.stall", k), 32'(stall), 32'(vecs[k].expStall));
            checkOutput($sformatf("vec%0d.flush", k), 32'(flush), 32'(vecs[k].expFlush));
            checkOutput($sformatf("vec%0d.redirect_valid", k), 32'(rif.redirect_valid_o), 32'h0);
            checkOutput($sformatf("vec%0d.cnt", k), cnt, 32'(expCnt));
            if (vecs[k].expStall != 5'b00000) expCnt++;
            @(posedge clk);
            #1;
        end
        applyStimulus(vecs[0]);

        // General exception with fetch stalled three cycles; a global stall while
        // pending must not stall or count.
        setExc(1'b1, 1'b0, 32'h0, 1'b0);
        checkCycle("exc.c0", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b01111);
        setExc(1'b0, 1'b0, 32'h0, 1'b0);
        global_stall = 1'b1;
        checkCycle("exc.c1", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b00001);
        global_stall = 1'b0;
        checkCycle("exc.c2", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b00001);
        rif.fetch_ready_i = 1'b1;
        checkCycle("exc.c3", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b00001);
        checkCycle("exc.done", 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000);
        @(negedge clk);
        checkOutput("exc.cnt", cnt, 32'(expCnt));
        @(posedge clk);
        #1;

        // ERET accepted in the same cycle returns straight to idle.
        setExc(1'b1, 1'b1, EPC, 1'b1);
        checkCycle("eret.c0", 1'b1, 1'b1, EPC, 5'b00000, 5'b01111);
        setExc(1'b0, 1'b0, 32'h0, 1'b1);
        checkCycle("eret.done", 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000);

        // Second exception while pending replaces the target and overrides a global stall.
        setExc(1'b1, 1'b0, 32'h0, 1'b0);
        checkCycle("re.c0", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b01111);
        setExc(1'b1, 1'b1, EPC, 1'b1);
        global_stall = 1'b1;
        checkCycle("re.c1", 1'b1, 1'b0, 32'h0, 5'b00000, 5'b01111);
        setExc(1'b0, 1'b0, 32'h0, 1'b0);
        global_stall = 1'b0;
        checkCycle("re.c2", 1'b1, 1'b1, EPC, 5'b00000, 5'b00001);
        rif.fetch_ready_i = 1'b1;
        checkCycle("re.c3", 1'b1, 1'b1, EPC, 5'b00000, 5'b00001);
        checkCycle("re.done", 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000);

        // Reset in the middle of a pending redirect.
        setExc(1'b1, 1'b0, 32'h0, 1'b0);
        checkCycle("rp.c0", 1'b1, 1'b1, EXC_VEC, 5'b00000, 5'b01111);
        setExc(1'b1, 1'b0, 32'h0, 1'b0);
        global_stall = 1'b1;
        resetn = 1'b0;
        #2;
        checkOutput("rp.redirect_valid", 32'(rif.redirect_valid_o), 32'h0);
        checkOutput("rp.redirect_pc", rif.redirect_pc_o, 32'h0);
        checkOutput("rp.stall", 32'(stall), 32'h0);
        checkOutput("rp.flush", 32'(flush), 32'h0);
        checkOutput("rp.cnt", cnt, 32'h0);
        @(posedge clk);
        #1;
        setExc(1'b0, 1'b0, 32'h0, 1'b0);
        global_stall = 1'b0;
        resetn = 1'b1;
        checkCycle("rp.post", 1'b0, 1'b0, 32'h0, 5'b00000, 5'b00000);

        // Twenty stalled cycles: the wide counter reads 20, the 4-bit one sticks at F.
        global_stall = 1'b1;
        for (int k = 0; k < 20; k++) begin
            checkCycle($sformatf("sat.c%0d", k), 1'b0, 1'b0, 32'h0, 5'b11111, 5'b00000);
        end
        global_stall = 1'b0;
        @(negedge clk);
        checkOutput("sat.cnt32", cnt, 32'd20);
        checkOutput("sat.cnt4", 32'(cnt4), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
